// File: rtl/jtag_rom_pkg.sv
// ----------------------------------------------------------------------------
// jtag_rom_pkg
// Shared constants and the ROM content function for the JTAG ROM data
// register. The "ROM" is a pure function of the address: the address byte
// is replicated across the word and XORed with a fixed seed, so no storage
// is needed.
// ----------------------------------------------------------------------------
package jtag_rom_pkg;

    localparam int DR_W   = 64;
    localparam int ADDR_W = 8;

    localparam logic [DR_W-1:0] ROM_SEED = 64'h0123_4567_89AB_CDEF;

    // Word returned for a given table address.
    function automatic logic [DR_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
        return {(DR_W / ADDR_W){addr}} ^ ROM_SEED;
    endfunction

endpackage

// File: rtl/jtag_rom_table.sv
// ----------------------------------------------------------------------------
// jtag_rom_table
// Combinational address-to-word lookup for the JTAG ROM data register.
//
// Ports:
//   i_addr  in  ADDR_W  table address
//   o_word  out DR_W    table word for i_addr
// ----------------------------------------------------------------------------
module jtag_rom_table
    import jtag_rom_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DR_W-1:0]   o_word
);

    assign o_word = rom_word(i_addr);

endmodule

// File: rtl/jtag_rom_dr.sv
// ----------------------------------------------------------------------------
// jtag_rom_dr
// 64-bit user data register behind a BSCAN-style TAP user primitive, backed
// by a 256-word read-only table. The host shifts an address into the DR and
// pulses UPDATE to latch it; a later CAPTURE loads the addressed table word,
// which is then shifted out LSB-first on TDO.
//
// Ports:
//   TCK                 in   functional clock (all state on rising edge)
//   rst_n               in   asynchronous active-low reset
//   clk_p               in   board clock, same net as TCK (not used by logic)
//   RESET               in   TAP test-logic-reset, synchronous, active-high
//   SEL                 in   user DR selected; gates CAPTURE/SHIFT/UPDATE
//   CAPTURE/SHIFT/UPDATE in  TAP DR strobes
//   RUNTEST, TMS        in   status only
//   TDI                 in   serial data in
//   TDO                 out  serial data out (dr[0])
//   i_dip[15:0]         in   switches; i_dip[15] selects LED view
//   LED[15:0]           out  dr[15:0] when i_dip[15]=1, else zero-extended addr
//   LED16_R/G/B, LED17_R/G/B out strobe indicators
// ----------------------------------------------------------------------------
module jtag_rom_dr
    import jtag_rom_pkg::*;
#(
    parameter int DR_W   = jtag_rom_pkg::DR_W,
    parameter int ADDR_W = jtag_rom_pkg::ADDR_W
) (
    input  logic        TCK,
    input  logic        rst_n,
    input  logic        clk_p,
    input  logic        RESET,
    input  logic        SEL,
    input  logic        CAPTURE,
    input  logic        SHIFT,
    input  logic        UPDATE,
    input  logic        RUNTEST,
    input  logic        TMS,
    input  logic        TDI,
    output logic        TDO,
    input  logic [15:0] i_dip,
    output logic [15:0] LED,
    output logic        LED16_R,
    output logic        LED16_G,
    output logic        LED16_B,
    output logic        LED17_R,
    output logic        LED17_G,
    output logic        LED17_B
);

    logic [DR_W-1:0]   r_dr;
    logic [ADDR_W-1:0] r_addr;
    logic [DR_W-1:0]   w_rom_word;

    // Inputs that exist only for board-level compatibility.
    logic w_unused;
    assign w_unused = ^{clk_p, TMS, i_dip[14:0]};

    jtag_rom_table u_table (
        .i_addr (r_addr),
        .o_word (w_rom_word)
    );

    // RESET outranks everything; among the SEL-gated strobes CAPTURE wins
    // over SHIFT, which wins over UPDATE.
    always_ff @(posedge TCK or negedge rst_n) begin
        if (!rst_n) begin
            r_dr   <= '0;
            r_addr <= '0;
        end else if (RESET) begin
            r_dr   <= '0;
            r_addr <= '0;
        end else if (SEL) begin
            if (CAPTURE) begin
                r_dr <= w_rom_word;
            end else if (SHIFT) begin
                r_dr <= {TDI, r_dr[DR_W-1:1]};
            end else if (UPDATE) begin
                r_addr <= r_dr[ADDR_W-1:0];
            end
        end
    end

    // TDO comes straight from the register so the host can sample it on the
    // falling edge that follows each capture/shift edge.
    assign TDO = r_dr[0];

    assign LED = i_dip[15] ? r_dr[15:0] : {{(16-ADDR_W){1'b0}}, r_addr};

    assign LED16_R = RESET;
    assign LED16_G = SEL & SHIFT;
    assign LED16_B = SEL & CAPTURE;
    assign LED17_R = SEL & UPDATE;
    assign LED17_G = RUNTEST;
    assign LED17_B = SEL;

endmodule

// File: tb/tb_jtag_rom_dr.sv
`timescale 1ns/1ps
module tb_jtag_rom_dr;

    logic        TCK = 1'b0;
    logic        rst_n = 1'b0;
    logic        RESET = 1'b0;
    logic        SEL = 1'b0;
    logic        CAPTURE = 1'b0;
    logic        SHIFT = 1'b0;
    logic        UPDATE = 1'b0;
    logic        RUNTEST = 1'b0;
    logic        TMS = 1'b0;
    logic        TDI = 1'b0;
    logic [15:0] i_dip = 16'h0000;
    logic        TDO;
    logic [15:0] LED;
    logic        LED16_R, LED16_G, LED16_B, LED17_R, LED17_G, LED17_B;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_q[$];

    always #5 TCK = ~TCK;

    jtag_rom_dr jtag_rom (
        .TCK     (TCK),
        .rst_n   (rst_n),
        .clk_p   (TCK),
        .RESET   (RESET),
        .SEL     (SEL),
        .CAPTURE (CAPTURE),
        .SHIFT   (SHIFT),
        .UPDATE  (UPDATE),
        .RUNTEST (RUNTEST),
        .TMS     (TMS),
        .TDI     (TDI),
        .TDO     (TDO),
        .i_dip   (i_dip),
        .LED     (LED),
        .LED16_R (LED16_R),
        .LED16_G (LED16_G),
        .LED16_B (LED16_B),
        .LED17_R (LED17_R),
        .LED17_G (LED17_G),
        .LED17_B (LED17_B)
    );

    typedef struct {
        logic [7:0]  addr;
        logic        dip15;
        logic [63:0] exp_word;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs[7];

    // Reference table content, built byte by byte.
    function automatic logic [63:0] model_rom(input logic [7:0] a);
        logic [63:0] seed;
        logic [63:0] r;
        seed = 64'h0123_4567_89AB_CDEF;
        r = '0;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = a ^ seed[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Called at a falling edge; applies strobes across one rising edge and
    // returns at the following falling edge with strobes cleared.
    task automatic step(input logic cap, input logic sh, input logic upd, input logic tdi);
        CAPTURE = cap; SHIFT = sh; UPDATE = upd; TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0;
    endtask

    // 64 shift edges: samples TDO before each edge, drives din LSB-first.
    task automatic shift64(input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < 64; i++) begin
            dout[i] = TDO;
            step(1'b0, 1'b1, 1'b0, din[i]);
        end
    endtask

    task automatic pop_check(input string name, input logic [63:0] got);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: got %h expected <scoreboard empty>", name, got);
        end else begin
            exp = sb_q.pop_front();
            check(name, got, exp);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [63:0] got;
        logic [63:0] junk;
        logic [63:0] w;
        logic [7:0]  a;
        logic [7:0]  last_addr;

        vecs[0] = '{8'h00, 1'b1, 64'h0123_4567_89AB_CDEF, 16'hCDEF};
        vecs[1] = '{8'h05, 1'b0, 64'h0426_4062_8CAE_C8EA, 16'h0005};
        vecs[2] = '{8'hFF, 1'b1, 64'hFEDC_BA98_7654_3210, 16'h3210};
        vecs[3] = '{8'hA5, 1'b1, 64'hA486_E0C2_2C0E_684A, 16'h684A};
        vecs[4] = '{8'h3C, 1'b0, 64'h3D1F_795B_B597_F1D3, 16'h003C};
        for (int k = 5; k < 7; k++) begin
            a = 8'($urandom_range(1, 254));
            w = model_rom(a);
            vecs[k] = '{a, k[0], w, (k[0] ? w[15:0] : {8'h00, a})};
        end

        // Reset state while rst_n is held low.
        RESET = 1'b1;
        #12;
        check("rst_tdo", TDO, 1'b0);
        i_dip = 16'h0000; #1;
        check("rst_led_addr", LED, 16'h0000);
        i_dip = 16'hA000; #1;
        check("rst_led_dr", LED, 16'h0000);
        check("rst_led16_r", LED16_R, 1'b1);
        @(negedge TCK);
        rst_n = 1'b1;
        SEL = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;

        // Table-driven: load address, capture, read back the word.
        last_addr = 8'h00;
        for (int k = 0; k < 7; k++) begin
            shift64({56'h0, vecs[k].addr}, junk);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            i_dip = 16'h2000; #1;
            check($sformatf("v%0d_addr", k), LED, {8'h00, vecs[k].addr});
            i_dip = {vecs[k].dip15, 15'h2000};
            step(1'b1, 1'b0, 1'b0, 1'b0);
            sb_q.push_back(vecs[k].exp_word);
            check($sformatf("v%0d_led", k), LED, vecs[k].exp_led);
            check($sformatf("v%0d_tdo0", k), TDO, vecs[k].exp_word[0]);
            shift64(64'h0, got);
            pop_check($sformatf("v%0d_word", k), got);
            last_addr = vecs[k].addr;
        end

        // SEL=0: strobes must not disturb dr or addr.
        w = model_rom(last_addr);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        SEL = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("sel0_tdo_a", TDO, w[0]);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("sel0_tdo_b", TDO, w[0]);
        i_dip = 16'h8000; #1;
        check("sel0_led_dr", LED, w[15:0]);
        i_dip = 16'h0000; #1;
        check("sel0_led_addr", LED, {8'h00, last_addr});
        SEL = 1'b1;
        sb_q.push_back(w);
        shift64(64'h0, got);
        pop_check("sel0_word", got);

        // CAPTURE and SHIFT on the same edge: capture wins.
        CAPTURE = 1'b1; SHIFT = 1'b1; TDI = 1'b1; #1;
        check("strobe_led16_g", LED16_G, 1'b1);
        check("strobe_led16_b", LED16_B, 1'b1);
        check("strobe_led17_b", LED17_B, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        i_dip = 16'h8000; #1;
        check("prio_led", LED, w[15:0]);
        sb_q.push_back(w);
        shift64(64'h0, got);
        pop_check("prio_word", got);

        // UPDATE strobe indicator.
        UPDATE = 1'b1; #1;
        check("strobe_led17_r", LED17_R, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        i_dip = 16'h0000; #1;
        check("update_addr_zero", LED, 16'h0000);

        // Reload a nonzero address, then RESET in the middle of a shift.
        shift64(64'h5A, junk);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        w = model_rom(8'h5A);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        check("midshift_tdo", TDO, w[10]);
        RESET = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("treset_tdo", TDO, 1'b0);
        check("treset_led16_r", LED16_R, 1'b1);
        i_dip = 16'h0000; #1;
        check("treset_addr", LED, 16'h0000);
        i_dip = 16'h8000; #1;
        check("treset_dr", LED, 16'h0000);
        RESET = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(64'h0123_4567_89AB_CDEF);
        shift64(64'h0, got);
        pop_check("treset_word", got);

        // Asynchronous rst_n between edges.
        shift64(64'h5A, junk);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_arst_tdo", TDO, w[0]);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tdo", TDO, 1'b0);
        i_dip = 16'h8000; #0.5;
        check("arst_led_dr", LED, 16'h0000);
        i_dip = 16'h0000; #0.5;
        check("arst_led_addr", LED, 16'h0000);
        @(negedge TCK);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
